// File: rtl/beat_decode_gen_if.sv
// Bus between the beat/decode stage and its environment: start/stop requests,
// IR opcode in; beats, instruction lines and status out. BEAT_SINGLE_STEP_EN adds step_mode/step.
interface beat_decode_gen_if #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
);
   logic             run;
   logic             stop;
   logic [OP_W-1:0]  ir_op;
   logic [7:0]       t;
   logic             ld;
   logic             add;
   logic             sub;
   logic             and_op;
   logic             or_op;
   logic             shl;
   logic             xor_op;
   logic             halt;
   logic             illegal;
   logic             running;
   logic             halted;
   logic [CNT_W-1:0] instr_count;
`ifdef BEAT_SINGLE_STEP_EN
   logic             step_mode;
   logic             step;

   modport master (
      output run, stop, ir_op, step_mode, step,
      input  t, ld, add, sub, and_op, or_op, shl, xor_op, halt,
      input  illegal, running, halted, instr_count
   );
   modport slave (
      input  run, stop, ir_op, step_mode, step,
      output t, ld, add, sub, and_op, or_op, shl, xor_op, halt,
      output illegal, running, halted, instr_count
   );
`else
   modport master (
      output run, stop, ir_op,
      input  t, ld, add, sub, and_op, or_op, shl, xor_op, halt,
      input  illegal, running, halted, instr_count
   );
   modport slave (
      input  run, stop, ir_op,
      output t, ld, add, sub, and_op, or_op, shl, xor_op, halt,
      output illegal, running, halted, instr_count
   );
`endif
endinterface

// File: rtl/beat_decode_gen.sv
// Beat generator and opcode decode stage feeding the control unit.
// Optional single-step gating is enabled with macro BEAT_SINGLE_STEP_EN.
module beat_decode_gen #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   beat_decode_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       t;
   logic [7:0]       lines;
   logic             illegal;
   logic             running;
   logic             halted;
   logic             stop_pend;
   logic [CNT_W-1:0] cnt;
   logic [OP_W-1:0]  op;
   logic             adv;

   // lines bit order: 0 LD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHL, 6 XOR, 7 HALT
   function automatic logic [7:0] decode(input logic [OP_W-1:0] code);
      logic [7:0] d;
      d = 8'h00;
      case (code)
         OP_W'(1):  d = 8'h01;
         OP_W'(2):  d = 8'h02;
         OP_W'(3):  d = 8'h04;
         OP_W'(4):  d = 8'h08;
         OP_W'(5):  d = 8'h10;
         OP_W'(6):  d = 8'h20;
         OP_W'(7):  d = 8'h40;
         OP_W'(15): d = 8'h80;
         default:   d = 8'h00;
      endcase
      return d;
   endfunction

   assign op = bus.ir_op;

`ifdef BEAT_SINGLE_STEP_EN
   assign adv = !bus.step_mode || bus.step;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         t         <= 8'h00;
         lines     <= 8'h00;
         illegal   <= 1'b0;
         running   <= 1'b0;
         halted    <= 1'b0;
         stop_pend <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (bus.run && !bus.stop) begin
                  state     <= RUN;
                  t         <= 8'h01;
                  running   <= 1'b1;
                  halted    <= 1'b0;
                  stop_pend <= 1'b0;
               end
            end
            RUN: begin
               if (adv) begin
                  t <= {t[6:0], t[7]};
                  if (bus.stop) stop_pend <= 1'b1;
                  if (t[2]) begin
                     lines <= decode(op);
                     if (decode(op) == 8'h00) illegal <= 1'b1;
                  end
                  // HALT retires at the end of T3 and drops any pending stop
                  if (t[3] && lines[7]) begin
                     state     <= HALTED;
                     t         <= 8'h00;
                     lines     <= 8'h00;
                     running   <= 1'b0;
                     halted    <= 1'b1;
                     stop_pend <= 1'b0;
                     cnt       <= cnt + CNT_W'(1);
                  end else if (t[7]) begin
                     lines <= 8'h00;
                     cnt   <= cnt + CNT_W'(1);
                     if (stop_pend || bus.stop) begin
                        state     <= IDLE;
                        t         <= 8'h00;
                        running   <= 1'b0;
                        stop_pend <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.t           = t;
   assign bus.ld          = lines[0];
   assign bus.add         = lines[1];
   assign bus.sub         = lines[2];
   assign bus.and_op      = lines[3];
   assign bus.or_op       = lines[4];
   assign bus.shl         = lines[5];
   assign bus.xor_op      = lines[6];
   assign bus.halt        = lines[7];
   assign bus.illegal     = illegal;
   assign bus.running     = running;
   assign bus.halted      = halted;
   assign bus.instr_count = cnt;

endmodule

// File: tb/tb_beat_decode_gen.sv
// Bench for beat_decode_gen: directed plan plus random instructions, two instances
// (CNT_W=16 and CNT_W=2) driven identically and checked against an instruction-level model.
module tb_beat_decode_gen;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   beat_decode_gen_if #(.OP_W(4), .CNT_W(16)) bus();
   beat_decode_gen_if #(.OP_W(4), .CNT_W(2))  bus2();

   beat_decode_gen #(.OP_W(4), .CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   beat_decode_gen #(.OP_W(4), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   assign bus2.run   = bus.run;
   assign bus2.stop  = bus.stop;
   assign bus2.ir_op = bus.ir_op;
`ifdef BEAT_SINGLE_STEP_EN
   assign bus2.step_mode = bus.step_mode;
   assign bus2.step      = bus.step;
`endif

   int          total  = 0;
   int          passed = 0;
   logic [31:0] exp_cnt;
   bit          exp_ill;
   bit          exp_run;
   bit          exp_halt;

   function automatic logic [7:0] ref_lines(input int op);
      case (op)
         1:  return 8'h01;
         2:  return 8'h02;
         3:  return 8'h04;
         4:  return 8'h08;
         5:  return 8'h10;
         6:  return 8'h20;
         7:  return 8'h40;
         15: return 8'h80;
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] et, input logic [7:0] el,
                          input bit eill, input bit erun, input bit ehalt);
      chk({tag, "/t"},       32'(bus.t), 32'(et));
      chk({tag, "/t_s"},     32'(bus2.t), 32'(et));
      chk({tag, "/lines"},   32'({bus.halt, bus.xor_op, bus.shl, bus.or_op,
                                  bus.and_op, bus.sub, bus.add, bus.ld}), 32'(el));
      chk({tag, "/lines_s"}, 32'({bus2.halt, bus2.xor_op, bus2.shl, bus2.or_op,
                                  bus2.and_op, bus2.sub, bus2.add, bus2.ld}), 32'(el));
      chk({tag, "/illegal"}, 32'(bus.illegal), 32'(eill));
      chk({tag, "/illegal_s"}, 32'(bus2.illegal), 32'(eill));
      chk({tag, "/running"}, 32'(bus.running), 32'(erun));
      chk({tag, "/running_s"}, 32'(bus2.running), 32'(erun));
      chk({tag, "/halted"},  32'(bus.halted), 32'(ehalt));
      chk({tag, "/halted_s"}, 32'(bus2.halted), 32'(ehalt));
      chk({tag, "/count"},   32'(bus.instr_count), exp_cnt & 32'hFFFF);
      chk({tag, "/count_s"}, 32'(bus2.instr_count), exp_cnt & 32'h3);
   endtask

   task automatic start();
      bus.run  = 1'b1;
      bus.stop = 1'b0;
      @(negedge clk);
      bus.run  = 1'b0;
      exp_run  = 1'b1;
      exp_halt = 1'b0;
   endtask

   task automatic hold_check(input string tag);
      bus.run  = 1'b1;
      bus.stop = 1'b1;
      @(negedge clk);
      bus.run  = 1'b0;
      bus.stop = 1'b0;
      chk_all(tag, 8'h00, 8'h00, exp_ill, 1'b0, exp_halt);
   endtask

   // One instruction from T0; stop_beat/rst_beat < 0 means not used.
   task automatic do_instr(input int op, input int stop_beat, input int rst_beat);
      bit pend;
      pend = 1'b0;
      if (!exp_run) start();
      for (int b = 0; b < 8; b++) begin
         chk_all($sformatf("op%0d_beat%0d", op, b), 8'(1 << b),
                 (b >= 3) ? ref_lines(op) : 8'h00, exp_ill, 1'b1, 1'b0);
         if (b == rst_beat) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n    = 1'b1;
            exp_cnt  = 0;
            exp_ill  = 1'b0;
            exp_run  = 1'b0;
            exp_halt = 1'b0;
            chk_all("mid_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
            return;
         end
         bus.ir_op = (b == 2) ? 4'(op) : 4'($urandom);
         bus.stop  = (b == stop_beat);
         if (b == stop_beat) pend = 1'b1;
         @(negedge clk);
         bus.stop = 1'b0;
         if (b == 2 && ref_lines(op) == 8'h00) exp_ill = 1'b1;
         if (b == 3 && op == 15) begin
            exp_cnt++;
            exp_run  = 1'b0;
            exp_halt = 1'b1;
            chk_all("halt_end", 8'h00, 8'h00, exp_ill, 1'b0, 1'b1);
            return;
         end
      end
      exp_cnt++;
      if (pend) begin
         exp_run = 1'b0;
         chk_all("stop_end", 8'h00, 8'h00, exp_ill, 1'b0, 1'b0);
      end else begin
         chk_all("wrap", 8'h01, 8'h00, exp_ill, 1'b1, 1'b0);
      end
   endtask

   initial begin
      int r;
      int op;
      int sb;
      rst_n     = 1'b0;
      bus.run   = 1'b0;
      bus.stop  = 1'b0;
      bus.ir_op = '0;
`ifdef BEAT_SINGLE_STEP_EN
      bus.step_mode = 1'b0;
      bus.step      = 1'b0;
`endif
      exp_cnt  = 0;
      exp_ill  = 1'b0;
      exp_run  = 1'b0;
      exp_halt = 1'b0;

      repeat (2) begin
         @(negedge clk);
         chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      rst_n = 1'b1;

      hold_check("idle_run_stop");
      do_instr(2, -1, -1);
      do_instr(9, -1, -1);
      do_instr(1, 1, -1);
      hold_check("idle_after_stop");
      do_instr(15, -1, -1);
      hold_check("halted_run_stop");
      do_instr(7, -1, -1);
      do_instr(15, 1, -1);
      do_instr(4, -1, -1);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       op = r + 1;
         else if (r == 7) op = 15;
         else if (r == 8) op = 0;
         else             op = $urandom_range(8, 14);
         sb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : -1;
         do_instr(op, sb, -1);
      end

      do_instr(3, -1, 4);
      do_instr(6, -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/beat_decode_gen.md
Name: beat_decode_gen

Overview:
- Timing/decode stage directly upstream of the model computer's combinational control unit.
- Generates the one-hot machine beats T0..T7 and the registered one-hot instruction lines LD/ADD/SUB/AND/OR/SHL/XOR/HALT that the control unit consumes.
- Latches the IR opcode during the fetch beat.
- Stops the machine on HALT or on an external stop request, and counts retired instructions.

Parameters:
- OP_W, 4, opcode width taken from IR.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- run  in  1  start request; level sampled each clock.
- stop  in  1  stop request; level sampled each clock; honoured at instruction boundary.
- ir_op  in  OP_W  opcode field from IR; meaningful while T2 is high.
- t  out  8  one-hot beats; t[k] drives Tk.
- ld, add, sub, and_op, or_op, shl, xor_op, halt  out  1 each  registered one-hot instruction lines.
- illegal  out  1  sticky flag: an undefined opcode was fetched.
- running  out  1  high in RUN state.
- halted  out  1  high in HALTED state.
- instr_count  out  CNT_W  number of retired instructions.

Behaviour:
- Reset (rst_n=0 at a clock edge): t=0, all instruction lines=0, illegal=0, running=0, halted=0, instr_count=0, state=IDLE. Reset mid-instruction aborts immediately; no retirement is counted.
- States: IDLE, RUN, HALTED. All outputs are registered; there is no combinational path from inputs to outputs.
- IDLE/HALTED, run=1 and stop=0: next state RUN; t=8'h01 on the next cycle, so T0 appears one clock after run is sampled; halted clears. run=1 with stop=1 means the block stays in its current state.
- RUN: t rotates left by one bit every clock, T0→T1→…→T7→T0. Exactly one bit is set at all times while in RUN.
- Opcode latch: on the edge where t[2]=1, ir_op is decoded and the instruction lines are registered, so they are valid from T3 through T7.
- Opcode map: 1 LD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SHL, 7 XOR, 15 HALT.
- Any other opcode: no instruction line is set (executes as NOP), and illegal is set and stays set until reset.
- On the T7→T0 edge, all instruction lines clear to 0 and instr_count increments, wrapping modulo 2^CNT_W.
- HALT: at the end of T3 (the edge leaving T3 with halt=1), state becomes HALTED.
  - t=0, halt line clears, halted=1, running=0.
  - instr_count increments once; the HALT counts as retired.
- stop: if stop=1 is seen on any RUN cycle, a pending flag is set. On the next T7→T0 edge, state becomes IDLE (t=0) instead of wrapping, and the instruction still retires.
- If stop and a HALT opcode coincide, HALT takes effect at T3 and the pending stop is discarded.
- run is ignored while in RUN.

Optional Feature:
- Macro BEAT_SINGLE_STEP_EN.
- Defined: adds ports step_mode (in, 1) and step (in, 1).
  - With step_mode=1 in RUN, t, the opcode latch, the counter and the stop/HALT transitions advance only on clocks where step=1; otherwise all state holds.
  - With step_mode=0, behaviour is identical to the free-running mode.
- Undefined: the ports are absent and the beat generator free-runs as specified.

Test Plan:
- Reset with rst_n=0 for 2 clocks, then run=1 for 1 clock → t=0 during reset; t=8'h01 exactly one clock after run is sampled; t=8'h02…8'h80 on successive cycles, then 8'h01.
- ir_op=2 during T2 → add=1 during T3..T7 and 0 at the following T0; instr_count goes 0→1 at the wrap.
- ir_op=15 during T2 → halt=1 during T3; the next cycle gives t=0, halted=1, running=0, instr_count=1. run=1 then restarts at T0 with halted=0.
- ir_op=9 during T2 → no instruction line set; illegal=1, stays 1 across later instructions until rst_n=0.
- stop pulsed during T1 → the instruction completes through T7; the next cycle gives t=0, running=0, halted=0, instr_count incremented by 1. Also with run=1 and stop=1 in IDLE → the block stays IDLE.
- CNT_W=2, 4 instructions executed → instr_count goes 3→0; rst_n=0 asserted during T4 → t=0 and instr_count=0 on the next cycle.
